// File: rtl/uparc_cop0_intc.sv
// uparc_cop0_intc: COP0 system registers, time stamp counter and interrupt
// controller for the uparc core.
// Optional feature: define UPARC_COP0_TIMER_IRQ_EN to build the TCMP compare
// register and the timer interrupt (IPEND[31], masked by IMASK[31]).
module uparc_cop0_intc #(
    parameter int NIRQ      = 8,
    parameter int TSC_WIDTH = 64
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                i_stall,
    input  logic                i_rd_en,
    input  logic [4:0]          i_rd_no,
    output logic [31:0]         o_rd_val,
    input  logic                i_wr_en,
    input  logic [4:0]          i_wr_no,
    input  logic [31:0]         i_wr_val,
    input  logic                i_rfe,
    input  logic                i_wait,
    input  logic                i_except_start,
    input  logic                i_except_dly_slt,
    input  logic [31:0]         i_except_raddr,
    input  logic [31:0]         i_except_raddr_dly,
    input  logic [4:0]          i_except_code,
    input  logic [NIRQ-1:0]     i_irq,
    output logic [21:0]         o_ivtbase,
    output logic                o_ie,
    output logic                o_irq_req,
    output logic                o_intr_wait
);
    localparam logic [31:0]          PRID    = 32'h0000_0A01;
    localparam logic [TSC_WIDTH-1:0] TSC_ONE = 1;

    logic [TSC_WIDTH-1:0] tsc;
    logic [31:0]          tschi_rd;
    logic [21:0]          ivt;
    logic                 psr_ie;
    logic                 sr_ie;
    logic                 bd;
    logic [4:0]           code;
    logic [31:0]          epc;
    logic [NIRQ-1:0]      imask;
    logic [NIRQ-1:0]      irq_s1;
    logic [NIRQ-1:0]      irq_s2;
    logic                 intr_wait;
    logic                 irq_req;
    logic [31:0]          tcmp_rd;
    logic                 tpend_bit;
    logic                 imask_t_bit;
    logic [31:0]          ipend_ext;
    logic [31:0]          imask_ext;
    logic                 wake;

    // One request per unstalled cycle: exception > RFE > WAIT > MTC0
    logic do_exc, do_rfe, do_wait, do_wr;
    assign do_exc  = i_except_start && !i_stall;
    assign do_rfe  = i_rfe && !i_stall && !i_except_start;
    assign do_wait = i_wait && !i_stall && !i_except_start && !i_rfe;
    assign do_wr   = i_wr_en && !i_stall && !i_except_start && !i_rfe && !i_wait;

    // Free-running time stamp counter, unaffected by stall
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) tsc <= '0;
        else       tsc <= tsc + TSC_ONE;
    end

    generate
        if (TSC_WIDTH > 32) begin : g_tschi
            logic [TSC_WIDTH-33:0] tschi;
            // Snapshot the upper TSC half whenever TSCLO is read, so a later
            // TSCHI read pairs consistently with it
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst)
                    tschi <= '0;
                else if (i_rd_en && i_rd_no == 5'h08 && !i_stall)
                    tschi <= tsc[TSC_WIDTH-1:32];
            end
            assign tschi_rd = 32'(tschi);
        end else begin : g_no_tschi
            assign tschi_rd = '0;
        end
    endgenerate

    // Two-flop synchronizer for the asynchronous interrupt lines
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
        end else begin
            irq_s1 <= i_irq;
            irq_s2 <= irq_s1;
        end
    end

`ifdef UPARC_COP0_TIMER_IRQ_EN
    logic [31:0] tcmp;
    logic        tpend;
    logic        imask_t;
    // Timer compare: sticky pending flag, cleared by any TCMP write
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tcmp    <= '0;
            tpend   <= 1'b0;
            imask_t <= 1'b0;
        end else begin
            if (do_wr && i_wr_no == 5'h12) begin
                tcmp  <= i_wr_val;
                tpend <= 1'b0;
            end else if (tsc[31:0] == tcmp) begin
                tpend <= 1'b1;
            end
            if (do_wr && i_wr_no == 5'h10)
                imask_t <= i_wr_val[31];
        end
    end
    assign tcmp_rd     = tcmp;
    assign tpend_bit   = tpend;
    assign imask_t_bit = imask_t;
`else
    assign tcmp_rd     = '0;
    assign tpend_bit   = 1'b0;
    assign imask_t_bit = 1'b0;
`endif

    // 32-bit views of pending and mask registers
    always_comb begin
        ipend_ext            = '0;
        ipend_ext[NIRQ-1:0]  = irq_s2;
        ipend_ext[31]        = tpend_bit;
        imask_ext            = '0;
        imask_ext[NIRQ-1:0]  = imask;
        imask_ext[31]        = imask_t_bit;
    end
    assign wake = |(ipend_ext & imask_ext);

    // Architectural register updates in priority order
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ivt    <= '0;
            psr_ie <= 1'b0;
            sr_ie  <= 1'b0;
            bd     <= 1'b0;
            code   <= '0;
            epc    <= '0;
            imask  <= '0;
        end else if (do_exc) begin
            psr_ie <= sr_ie;
            sr_ie  <= 1'b0;
            bd     <= i_except_dly_slt;
            epc    <= i_except_dly_slt ? i_except_raddr_dly : i_except_raddr;
            code   <= i_except_code;
        end else if (do_rfe) begin
            sr_ie  <= psr_ie;
            psr_ie <= 1'b0;
        end else if (do_wr) begin
            case (i_wr_no)
                5'h0A: ivt    <= i_wr_val[31:10];
                5'h0B: psr_ie <= i_wr_val[0];
                5'h0C: sr_ie  <= i_wr_val[0];
                5'h0D: begin
                    bd   <= i_wr_val[31];
                    code <= i_wr_val[6:2];
                end
                5'h0E: epc    <= i_wr_val;
                5'h10: imask  <= i_wr_val[NIRQ-1:0];
                default: ;
            endcase
        end
    end

    // Wait-for-interrupt: wakes on any unmasked pending line regardless of SR.IE
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)        intr_wait <= 1'b0;
        else if (do_exc)  intr_wait <= 1'b0;
        else if (do_wait) intr_wait <= 1'b1;
        else if (wake)    intr_wait <= 1'b0;
    end

    // Registered interrupt request to the control unit
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) irq_req <= 1'b0;
        else       irq_req <= sr_ie && wake;
    end

    // Combinational read mux, always showing pre-edge state
    always_comb begin
        o_rd_val = '0;
        if (i_rd_en) begin
            case (i_rd_no)
                5'h08: o_rd_val = tsc[31:0];
                5'h09: o_rd_val = tschi_rd;
                5'h0A: o_rd_val = {ivt, 10'b0};
                5'h0B: o_rd_val = {31'b0, psr_ie};
                5'h0C: o_rd_val = {31'b0, sr_ie};
                5'h0D: o_rd_val = {bd, 24'b0, code, 2'b0};
                5'h0E: o_rd_val = epc;
                5'h0F: o_rd_val = PRID;
                5'h10: o_rd_val = imask_ext;
                5'h11: o_rd_val = ipend_ext;
                5'h12: o_rd_val = tcmp_rd;
                default: o_rd_val = '0;
            endcase
        end
    end

    assign o_ivtbase   = ivt;
    assign o_ie        = sr_ie;
    assign o_irq_req   = irq_req;
    assign o_intr_wait = intr_wait;

endmodule

// File: tb/tb_uparc_cop0_intc.sv
// Directed testbench for uparc_cop0_intc (default parameters).
module tb_uparc_cop0_intc;
    localparam logic [31:0] PRID = 32'h0000_0A01;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_stall, i_rd_en, i_wr_en, i_rfe, i_wait;
    logic [4:0]  i_rd_no, i_wr_no, i_except_code;
    logic [31:0] i_wr_val, i_except_raddr, i_except_raddr_dly;
    logic        i_except_start, i_except_dly_slt;
    logic [7:0]  i_irq;
    logic [31:0] o_rd_val;
    logic [21:0] o_ivtbase;
    logic        o_ie, o_irq_req, o_intr_wait;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uparc_cop0_intc dut (
        .clk(clk), .nrst(nrst), .i_stall(i_stall),
        .i_rd_en(i_rd_en), .i_rd_no(i_rd_no), .o_rd_val(o_rd_val),
        .i_wr_en(i_wr_en), .i_wr_no(i_wr_no), .i_wr_val(i_wr_val),
        .i_rfe(i_rfe), .i_wait(i_wait),
        .i_except_start(i_except_start), .i_except_dly_slt(i_except_dly_slt),
        .i_except_raddr(i_except_raddr), .i_except_raddr_dly(i_except_raddr_dly),
        .i_except_code(i_except_code), .i_irq(i_irq),
        .o_ivtbase(o_ivtbase), .o_ie(o_ie), .o_irq_req(o_irq_req),
        .o_intr_wait(o_intr_wait)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] no, input logic [31:0] exp);
        i_rd_en = 1'b1;
        i_rd_no = no;
        #1;
        check(tag, o_rd_val, exp);
        i_rd_en = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [4:0] no, input logic [31:0] val);
        i_wr_en  = 1'b1;
        i_wr_no  = no;
        i_wr_val = val;
        tick();
        i_wr_en  = 1'b0;
    endtask

    initial begin
        bit found;
        nrst = 1'b0;
        i_stall = 0; i_rd_en = 0; i_wr_en = 0; i_rfe = 0; i_wait = 0;
        i_rd_no = 0; i_wr_no = 0; i_wr_val = 0; i_except_code = 0;
        i_except_start = 0; i_except_dly_slt = 0;
        i_except_raddr = 0; i_except_raddr_dly = 0; i_irq = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ie", o_ie, 0);
        check("rst_wait", o_intr_wait, 0);
        check("rst_irq_req", o_irq_req, 0);
        check("rst_ivtbase", o_ivtbase, 0);
        i_rd_en = 1; i_rd_no = 5'h0F; #1;
        check("rst_prid", o_rd_val, PRID);
        i_rd_en = 0;
        nrst = 1'b1;
        tick();
        rd("prid", 5'h0F, PRID);
        rd("sr_rst", 5'h0C, 0);
        rd("cause_rst", 5'h0D, 0);
        rd("epc_rst", 5'h0E, 0);
        rd("unmapped_rd", 5'h00, 0);

        // register map and write masking
        wr(5'h0A, 32'hABCD_E7FF);
        rd("ivt", 5'h0A, 32'hABCD_E400);
        check("ivtbase", o_ivtbase, 22'h2AF379);
        wr(5'h0F, 32'h0);
        rd("prid_ro", 5'h0F, PRID);
        wr(5'h13, 32'hFFFF_FFFF);
        rd("unmapped_wr", 5'h13, 0);
        wr(5'h0D, 32'hFFFF_FFFF);
        rd("cause_wr", 5'h0D, 32'h8000_007C);
        wr(5'h0D, 32'h0);
        wr(5'h0B, 32'hFFFF_FFFE);
        rd("psr_bit0", 5'h0B, 0);

        // interrupt latency: request exactly 3 edges after the line rises
        wr(5'h10, 32'h1);
        wr(5'h0C, 32'h1);
        check("ie_set", o_ie, 1);
        i_rd_en = 1; i_rd_no = 5'h11; i_irq = 8'h01;
        tick();
        check("irq_req_c1", o_irq_req, 0);
        check("ipend_c1", o_rd_val, 0);
        tick();
        check("irq_req_c2", o_irq_req, 0);
        check("ipend_c2", o_rd_val, 1);
        tick();
        check("irq_req_c3", o_irq_req, 1);
        i_irq = 8'h00;
        tick(); tick();
        check("ipend_drop", o_rd_val, 0);
        check("irq_req_lag", o_irq_req, 1);
        tick();
        check("irq_req_drop", o_irq_req, 0);
        i_irq = 8'h02;
        repeat (3) tick();
        check("ipend_masked", o_rd_val, 2);
        check("irq_req_masked", o_irq_req, 0);
        i_irq = 8'h00; i_rd_en = 0;
        repeat (3) tick();

        // exception entry in a delay slot, then RFE
        i_except_start = 1; i_except_dly_slt = 1;
        i_except_raddr = 32'h2000; i_except_raddr_dly = 32'h1000; i_except_code = 5'd5;
        tick();
        i_except_start = 0;
        check("exc_ie", o_ie, 0);
        rd("exc_sr", 5'h0C, 0);
        rd("exc_psr", 5'h0B, 1);
        rd("exc_epc", 5'h0E, 32'h1000);
        rd("exc_cause", 5'h0D, 32'h8000_0014);
        i_rfe = 1; tick(); i_rfe = 0;
        rd("rfe_sr", 5'h0C, 1);
        rd("rfe_psr", 5'h0B, 0);

        // exception outside a delay slot
        i_except_start = 1; i_except_dly_slt = 0; i_except_code = 5'd3;
        tick();
        i_except_start = 0;
        rd("exc2_epc", 5'h0E, 32'h2000);
        rd("exc2_cause", 5'h0D, 32'h0000_000C);

        // stall blocks RFE and MTC0
        i_stall = 1; i_rfe = 1; i_wr_en = 1; i_wr_no = 5'h0E; i_wr_val = 32'hDEAD;
        tick();
        i_stall = 0; i_rfe = 0; i_wr_en = 0;
        rd("stall_rfe", 5'h0C, 0);
        rd("stall_wr", 5'h0E, 32'h2000);

        // priority: exception beats MTC0; RFE beats WAIT and MTC0
        i_except_start = 1; i_except_raddr = 32'h3000;
        i_wr_en = 1; i_wr_no = 5'h0E; i_wr_val = 32'hDEAD;
        tick();
        i_except_start = 0; i_wr_en = 0;
        rd("prio_exc_wr", 5'h0E, 32'h3000);
        wr(5'h0B, 32'h1);
        i_rfe = 1; i_wait = 1; i_wr_en = 1; i_wr_no = 5'h0B; i_wr_val = 32'h1;
        tick();
        i_rfe = 0; i_wait = 0; i_wr_en = 0;
        check("prio_rfe_wait", o_intr_wait, 0);
        rd("prio_rfe_sr", 5'h0C, 1);
        rd("prio_rfe_psr", 5'h0B, 0);

        // same-cycle read/write returns pre-edge value
        i_rd_en = 1; i_rd_no = 5'h0C;
        i_wr_en = 1; i_wr_no = 5'h0C; i_wr_val = 32'h0;
        #1;
        check("nobyp_pre", o_rd_val, 1);
        tick();
        i_wr_en = 0;
        check("nobyp_post", o_rd_val, 0);
        i_rd_en = 0;

        // WAIT wakes on an unmasked pending line even with SR.IE=0
        wr(5'h10, 32'h0);
        i_wait = 1; tick(); i_wait = 0;
        check("wait_set", o_intr_wait, 1);
        i_irq = 8'h04;
        repeat (3) tick();
        check("wait_hold", o_intr_wait, 1);
        wr(5'h10, 32'h4);
        tick();
        check("wait_wake", o_intr_wait, 0);
        check("wait_no_irq", o_irq_req, 0);
        i_irq = 8'h00;
        wr(5'h10, 32'h0);
        repeat (3) tick();
        i_wait = 1; tick(); i_wait = 0;
        check("wait_set2", o_intr_wait, 1);
        i_except_start = 1; tick(); i_except_start = 0;
        check("wait_exc", o_intr_wait, 0);

        // TSC: TSCHI shadow captured on TSCLO read
        @(negedge clk);
        force dut.tsc = 64'h0000_0001_FFFF_FFFD;
        @(negedge clk);
        release dut.tsc;
        i_rd_en = 1; i_rd_no = 5'h09; #1;
        check("tschi_pre", o_rd_val, 0);
        i_rd_en = 0;
        tick(); tick();
        i_rd_en = 1; i_rd_no = 5'h08; #1;
        check("tsclo_max", o_rd_val, 32'hFFFF_FFFF);
        tick();
        i_rd_no = 5'h09; #1;
        check("tschi_latched", o_rd_val, 1);
        repeat (5) tick();
        check("tschi_hold", o_rd_val, 1);
        i_rd_no = 5'h08; #1;
        check("tsclo_wrap", o_rd_val, 5);
        i_rd_en = 0;
        tick();

        // reset aborts a pending exception entry
        i_except_start = 1; i_except_raddr = 32'h4444; i_except_dly_slt = 0;
        #2;
        nrst = 1'b0;
        #1;
        check("rst_async_ivt", o_ivtbase, 0);
        tick();
        i_except_start = 0;
        nrst = 1'b1;
        tick();
        rd("rst_abort_epc", 5'h0E, 0);
        rd("rst_abort_psr", 5'h0B, 0);

`ifdef UPARC_COP0_TIMER_IRQ_EN
        // timer compare at TSC==0x20
        wr(5'h12, 32'h20);
        rd("tpend_clr_wr", 5'h11, 0);
        wr(5'h10, 32'h8000_0000);
        wr(5'h0C, 32'h1);
        i_rd_en = 1; i_rd_no = 5'h08;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (o_rd_val == 32'h20) begin
                found = 1;
                break;
            end
            tick();
        end
        check("tcmp_reach", {31'b0, found}, 1);
        if (found) begin
            i_rd_no = 5'h11; #1;
            check("tpend_pre", o_rd_val, 0);
            tick();
            check("tpend_set", o_rd_val, 32'h8000_0000);
            check("timer_irq_pre", o_irq_req, 0);
            tick();
            check("timer_irq", o_irq_req, 1);
            i_rd_en = 0;
            wr(5'h12, 32'h20);
            rd("tpend_clr", 5'h11, 0);
        end
        i_rd_en = 0;
`else
        wr(5'h12, 32'hFFFF_FFFF);
        rd("tcmp_absent", 5'h12, 0);
        wr(5'h10, 32'hFFFF_FFFF);
        rd("imask_no_t", 5'h10, 32'h0000_00FF);
        rd("ipend_no_t", 5'h11, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uparc_cop0_intc.md
UPARC_COP0_INTC -- requirements
Module: uparc_cop0_intc

Interface
REQ-001 SHALL provide parameter NIRQ, default 8, meaning number of external interrupt lines (legal 1..16).
REQ-002 SHALL provide parameter TSC_WIDTH, default 64, meaning time stamp counter width (legal 32..64).
REQ-003 SHALL have ports (name  direction  width  meaning):
 clk  in  1  clock
 nrst  in  1  reset, asynchronous, active-low
 i_stall  in  1  core stall; freezes all architectural updates except TSC and synchronizers
 i_rd_en  in  1  decode-stage COP0 register read
 i_rd_no  in  5  read register number
 o_rd_val  out  32  read data, combinational
 i_wr_en  in  1  writeback-stage MTC0
 i_wr_no  in  5  write register number
 i_wr_val  in  32  write data
 i_rfe  in  1  writeback-stage RFE
 i_wait  in  1  writeback-stage WAIT
 i_except_start  in  1  exception entry
 i_except_dly_slt  in  1  faulting instruction is in a delay slot
 i_except_raddr  in  32  return address, normal case
 i_except_raddr_dly  in  32  return address, delay-slot case
 i_except_code  in  5  exception cause code
 i_irq  in  NIRQ  asynchronous level interrupt lines, active-high
 o_ivtbase  out  22  IVT base bits [31:10]
 o_ie  out  1  SR.IE
 o_irq_req  out  1  interrupt request to control unit, registered
 o_intr_wait  out  1  wait-for-interrupt state

Function
REQ-004 SHALL decode the register map: 0x08 TSCLO, 0x09 TSCHI, 0x0A IVT, 0x0B PSR, 0x0C SR, 0x0D CAUSE, 0x0E EPC, 0x0F PRID (R/O), 0x10 IMASK, 0x11 IPEND (R/O), 0x12 TCMP; other numbers read 0 and ignore writes.
REQ-005 SHALL read TSCLO as live TSC[31:0] and, when i_rd_en && i_rd_no==0x08 && !i_stall, latch TSC[TSC_WIDTH-1:32] into the TSCHI shadow on that edge.
REQ-006 SHALL read TSCHI as the zero-extended shadow; TSCHI SHALL read 0 when TSC_WIDTH==32.
REQ-007 SHALL increment TSC by 1 every cycle regardless of i_stall, wrapping from all-ones to 0.
REQ-008 SHALL read PSR/SR as {31'b0, IE}, CAUSE as {BD, 24'b0, code[4:0], 2'b0}, IVT as {ivt, 10'b0}, IMASK as zero-extended NIRQ bits.
REQ-009 SHALL synchronise i_irq through two flops; IPEND[NIRQ-1:0] SHALL equal the synchronised levels (2-cycle latency, no latching).
REQ-010 SHALL compute o_irq_req registered as SR.IE && |(IPEND & {TPEND-enabled, IMASK}), one cycle after IPEND.
REQ-011 SHALL on i_wr_en && !i_stall update the addressed register; SR/PSR take bit 0, CAUSE takes bit 31 and bits [6:2], IVT takes [31:10].
REQ-012 SHALL on i_rfe && !i_stall set SR.IE<=PSR.IE and PSR.IE<=0.
REQ-013 SHALL on i_wait && !i_stall set intr_wait; intr_wait SHALL clear on exception entry or when |(IPEND & IMASK) is 1, independent of SR.IE.
REQ-014 SHALL on i_except_start && !i_stall set PSR.IE<=SR.IE, SR.IE<=0, BD<=i_except_dly_slt, EPC<=dly_slt ? raddr_dly : raddr, code<=i_except_code, intr_wait<=0.
REQ-015 SHALL give priority i_except_start > i_rfe > i_wait > i_wr_en when asserted in the same unstalled cycle; lower-priority requests are dropped.
REQ-016 SHALL return the value being written on a same-cycle read of the same register only after the edge (no bypass); read data reflects pre-edge state.

Reset
REQ-017 SHALL on nrst low clear TSC, TSCHI shadow, IVT, PSR.IE, SR.IE, BD, code, EPC, IMASK, TCMP, TPEND, synchronizers, intr_wait and o_irq_req; o_ivtbase=0, o_ie=0, o_intr_wait=0, o_rd_val=PRID only when addressed.
REQ-018 SHALL treat reset mid-operation as abort: no pending write, RFE or exception entry survives.

Configuration
REQ-019 SHALL, with UPARC_COP0_TIMER_IRQ_EN defined, implement TCMP: TPEND (IPEND[31]) sets when TSC[31:0]==TCMP, is sticky, clears on any TCMP write (write wins over same-cycle match), and is masked by IMASK[31].
REQ-020 SHALL, without UPARC_COP0_TIMER_IRQ_EN, read TCMP and IPEND[31] as 0, ignore TCMP writes and include no compare logic.

Verification
REQ-021 Reset, read 0x0F -> o_rd_val=PRID; read 0x0C -> 0; o_irq_req=0.
REQ-022 MTC0 IMASK=0x01, SR=1, pulse i_irq[0] high -> o_irq_req=1 exactly 3 cycles after i_irq rises.
REQ-023 SR=1, i_except_start with dly_slt=1, raddr_dly=0x1000, code=5 -> SR=0, PSR=1, EPC=0x1000, CAUSE=0x80000014; then i_rfe -> SR=1, PSR=0.
REQ-024 Read TSCLO when TSC=0x1_FFFFFFFF -> TSCLO=0xFFFFFFFF, later TSCHI=0x1 regardless of TSC progress.
REQ-025 i_wait with IMASK=0, then irq[2] with IMASK[2]=1 and SR=0 -> o_intr_wait clears, o_irq_req stays 0.
REQ-026 (TIMER_IRQ_EN) TCMP=0x20, IMASK[31]=1, SR=1 -> TPEND at TSC==0x20, o_irq_req next cycle; TCMP write clears TPEND.
